// File: rtl/spi_command_executor.sv
// spi_command_executor: executes parsed SPI sprite commands.
// SAVE_SPRITE payloads become sprite RAM write strobes. DRAW_SPRITE payloads
// are packed into 48-bit draw requests and queued for the renderer.
module spi_command_executor #(
    parameter int         SPRITE_ID_WIDTH     = 4,
    parameter int         DRAW_FIFO_DEPTH     = 4,
    parameter logic [7:0] COMMAND_SAVE_SPRITE = 8'h10,
    parameter logic [7:0] COMMAND_DRAW_SPRITE = 8'h11
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       abort,
    input  logic                       byte_read,
    input  logic                       cmd_byte,
    input  logic [7:0]                 command,
    input  logic [7:0]                 data,
    input  logic [15:0]                data_index,
    output logic                       sprite_we,
    output logic [SPRITE_ID_WIDTH+8:0] sprite_addr,
    output logic [7:0]                 sprite_wdata,
    output logic                       save_done,
    output logic                       draw_valid,
    input  logic                       draw_ready,
    output logic [47:0]                draw_data,
    output logic                       draw_overflow,
    output logic                       busy
);

    localparam int AW = $clog2(DRAW_FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SAVE_ID, SAVE_PIX, DRAW_COLLECT} state_t;

    typedef struct packed {
        logic [7:0]  id;
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  flags;
    } draw_req_t;

    state_t                     state_q, state_n;
    logic [SPRITE_ID_WIDTH-1:0] sprite_id_q;
    logic [9:0]                 pix_idx_q;   // data_index expected for next pixel (1..512)
    logic [2:0]                 col_idx_q;   // data_index expected for next draw byte (0..5)
    logic [39:0]                col_q;       // first five draw bytes, oldest in the top byte

    logic wr_fire, done_fire, push_req, id_load, col_clear, col_load;

    // fifo state
    draw_req_t         fifo_mem [DRAW_FIFO_DEPTH];
    logic [AW-1:0]     wp_q, rp_q;
    logic [AW:0]       cnt_q;
    logic              full, pop, push_ok;
    draw_req_t         push_entry;

    assign busy       = (state_q != IDLE);
    assign push_entry = draw_req_t'({col_q, data});

    // State register
    always_ff @(posedge clock) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_n;
    end

    // Next state and per-byte actions; abort wins over any byte, an opcode
    // byte always restarts decoding as if from IDLE
    always_comb begin
        state_n   = state_q;
        wr_fire   = 1'b0;
        done_fire = 1'b0;
        push_req  = 1'b0;
        id_load   = 1'b0;
        col_clear = 1'b0;
        col_load  = 1'b0;
        if (abort) begin
            state_n = IDLE;
        end else if (byte_read && cmd_byte) begin
            if (data == COMMAND_SAVE_SPRITE) begin
                state_n = SAVE_ID;
            end else if (data == COMMAND_DRAW_SPRITE) begin
                state_n   = DRAW_COLLECT;
                col_clear = 1'b1;
            end else begin
                state_n = IDLE;
            end
        end else if (byte_read) begin
            case (state_q)
                SAVE_ID: begin
                    if (command == COMMAND_SAVE_SPRITE && data_index == 16'd0) begin
                        id_load = 1'b1;
                        state_n = SAVE_PIX;
                    end else begin
                        state_n = IDLE;
                    end
                end
                SAVE_PIX: begin
                    if (command == COMMAND_SAVE_SPRITE && data_index == 16'(pix_idx_q)) begin
                        wr_fire = 1'b1;
                        if (pix_idx_q == 10'd512) begin
                            done_fire = 1'b1;
                            state_n   = IDLE;
                        end
                    end else begin
                        state_n = IDLE;
                    end
                end
                DRAW_COLLECT: begin
                    if (command == COMMAND_DRAW_SPRITE && data_index == 16'(col_idx_q)) begin
                        if (col_idx_q == 3'd5) begin
                            push_req = 1'b1;
                            state_n  = IDLE;
                        end else begin
                            col_load = 1'b1;
                        end
                    end else begin
                        state_n = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sprite id latch, pixel/collect counters and draw byte assembly
    always_ff @(posedge clock) begin
        if (!reset) begin
            sprite_id_q <= '0;
            pix_idx_q   <= '0;
            col_idx_q   <= '0;
            col_q       <= '0;
        end else begin
            if (id_load) begin
                sprite_id_q <= data[SPRITE_ID_WIDTH-1:0];
                pix_idx_q   <= 10'd1;
            end else if (wr_fire) begin
                pix_idx_q <= pix_idx_q + 10'd1;
            end
            if (col_clear) begin
                col_idx_q <= '0;
            end else if (col_load) begin
                col_idx_q <= col_idx_q + 3'd1;
                col_q     <= {col_q[31:0], data};
            end
        end
    end

    // Registered sprite RAM port; address/data hold between writes
    always_ff @(posedge clock) begin
        if (!reset) begin
            sprite_we    <= 1'b0;
            sprite_addr  <= '0;
            sprite_wdata <= '0;
            save_done    <= 1'b0;
        end else begin
            sprite_we <= wr_fire;
            save_done <= done_fire;
            if (wr_fire) begin
                sprite_addr  <= {sprite_id_q, 9'(pix_idx_q - 10'd1)};
                sprite_wdata <= data;
            end
        end
    end

    // Draw FIFO: a full FIFO still accepts when the head leaves the same cycle
    assign full       = (cnt_q == (AW+1)'(DRAW_FIFO_DEPTH));
    assign draw_valid = (cnt_q != '0);
    assign pop        = draw_valid & draw_ready;
    assign push_ok    = push_req & (~full | pop);
    assign draw_data  = draw_valid ? fifo_mem[rp_q] : 48'd0;

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clock) begin
        if (!reset) begin
            wp_q          <= '0;
            rp_q          <= '0;
            cnt_q         <= '0;
            draw_overflow <= 1'b0;
        end else begin
            if (push_ok) wp_q <= wp_q + 1'b1;
            if (pop)     rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);
            if (push_req && full && !pop) draw_overflow <= 1'b1;
        end
    end

    // FIFO storage; contents are masked by draw_valid so no reset needed
    always_ff @(posedge clock) begin
        if (push_ok) fifo_mem[wp_q] <= push_entry;
    end

endmodule

// File: tb/tb_spi_command_executor.sv
// Testbench for spi_command_executor: table of draw vectors plus directed
// SAVE / abort / overflow / reset sequences, checked through scoreboards.
module tb_spi_command_executor;

    localparam logic [7:0] SAVE = 8'h10;
    localparam logic [7:0] DRAW = 8'h11;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        abort = 1'b0;
    logic        byte_read = 1'b0;
    logic        cmd_byte = 1'b0;
    logic [7:0]  command = 8'h00;
    logic [7:0]  data = 8'h00;
    logic [15:0] data_index = 16'h0;
    logic        draw_ready = 1'b0;
    logic        sprite_we, save_done, draw_valid, draw_overflow, busy;
    logic [12:0] sprite_addr;
    logic [7:0]  sprite_wdata;
    logic [47:0] draw_data;

    spi_command_executor #(
        .SPRITE_ID_WIDTH(4), .DRAW_FIFO_DEPTH(4),
        .COMMAND_SAVE_SPRITE(SAVE), .COMMAND_DRAW_SPRITE(DRAW)
    ) dut (
        .clock(clock), .reset(reset), .abort(abort), .byte_read(byte_read),
        .cmd_byte(cmd_byte), .command(command), .data(data), .data_index(data_index),
        .sprite_we(sprite_we), .sprite_addr(sprite_addr), .sprite_wdata(sprite_wdata),
        .save_done(save_done), .draw_valid(draw_valid), .draw_ready(draw_ready),
        .draw_data(draw_data), .draw_overflow(draw_overflow), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  id;
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  flags;
        logic [47:0] exp;
    } dvec_t;

    typedef struct {
        logic [12:0] addr;
        logic [7:0]  wd;
        logic        done;
    } wexp_t;

    dvec_t       tbl [6];
    wexp_t       wq [$];
    logic [47:0] dq [$];
    wexp_t       mon_e;
    int n_vec = 0, n_err = 0, n_writes = 0, n_done = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: sprite writes and FIFO pops checked against the queues
    always @(negedge clock) begin
        if (sprite_we) begin
            n_writes++;
            if (save_done) n_done++;
            chk("write_expected", 64'(wq.size() != 0), 64'd1);
            if (wq.size() != 0) begin
                mon_e = wq.pop_front();
                chk("write_addr", 64'(sprite_addr), 64'(mon_e.addr));
                chk("write_data", 64'(sprite_wdata), 64'(mon_e.wd));
                chk("write_save_done", 64'(save_done), 64'(mon_e.done));
            end
        end else if (save_done) begin
            chk("stray_save_done", 64'(save_done), 64'd0);
        end
        if (draw_valid && draw_ready) begin
            chk("pop_expected", 64'(dq.size() != 0), 64'd1);
            if (dq.size() != 0) chk("pop_draw_data", 64'(draw_data), 64'(dq.pop_front()));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // Drive one byte (caller is #1 after an edge), return #1 after the next edge
    task automatic send(input logic is_cmd, input logic [7:0] cmd, input logic [7:0] d,
                        input logic [15:0] idx);
        byte_read = 1'b1; cmd_byte = is_cmd; command = cmd; data = d; data_index = idx;
        @(posedge clock); #1;
        byte_read = 1'b0; cmd_byte = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clock); #1; end
    endtask

    task automatic send_draw(input int v, input logic rdy_last);
        send(1'b1, 8'h00, DRAW, 16'd0);
        send(1'b0, DRAW, tbl[v].id, 16'd0);
        send(1'b0, DRAW, tbl[v].x[15:8], 16'd1);
        send(1'b0, DRAW, tbl[v].x[7:0], 16'd2);
        send(1'b0, DRAW, tbl[v].y[15:8], 16'd3);
        send(1'b0, DRAW, tbl[v].y[7:0], 16'd4);
        draw_ready = rdy_last;
        send(1'b0, DRAW, tbl[v].flags, 16'd5);
        draw_ready = 1'b0;
    endtask

    task automatic pop1;
        draw_ready = 1'b1;
        @(posedge clock); #1;
        draw_ready = 1'b0;
    endtask

    // Full 512-pixel save; pixel k carries (k*mul + off)
    task automatic save_all(input logic [3:0] id, input int mul, input int off);
        send(1'b1, 8'h00, SAVE, 16'd0);
        chk("busy_after_opcode", 64'(busy), 64'd1);
        send(1'b0, SAVE, {4'h0, id}, 16'd0);
        for (int k = 1; k <= 512; k++) begin
            wq.push_back('{addr: 13'({id, 9'd0}) + 13'(k - 1),
                           wd: 8'((k - 1) * mul + off), done: (k == 512)});
            send(1'b0, SAVE, 8'((k - 1) * mul + off), 16'(k));
        end
    endtask

    initial begin
        int w0, d0;
        tbl[0] = '{8'h07, 16'h012C, 16'h00C8, 8'h81, 48'h07012C00C881};
        tbl[1] = '{8'hFF, 16'hFFFF, 16'hFFFF, 8'hFF, 48'hFFFFFFFFFFFF};
        tbl[2] = '{8'h01, 16'h0203, 16'h0405, 8'h06, 48'h010203040506};
        tbl[3] = '{8'hA5, 16'h5AA5, 16'hC33C, 8'h0F, 48'hA55AA5C33C0F};
        tbl[4] = '{8'h10, 16'h8000, 16'h0001, 8'hF0, 48'h1080000001F0};
        tbl[5] = '{8'h3C, 16'h1234, 16'h5678, 8'h9A, 48'h3C123456789A};

        // reset state
        idle(2);
        chk("rst_sprite_we", 64'(sprite_we), 64'd0);
        chk("rst_draw_valid", 64'(draw_valid), 64'd0);
        chk("rst_draw_data", 64'(draw_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        idle(1);

        // full SAVE: id 3, pixels 0x00..0xFF twice -> addr 0x600..0x7FF
        w0 = n_writes; d0 = n_done;
        save_all(4'h3, 1, 0);
        idle(2);
        chk("save_write_count", 64'(n_writes - w0), 64'd512);
        chk("save_done_count", 64'(n_done - d0), 64'd1);
        chk("save_busy_end", 64'(busy), 64'd0);

        // table-driven draws, one at a time
        for (int v = 0; v < 4; v++) begin
            send_draw(v, 1'b0);
            dq.push_back(tbl[v].exp);
            chk("draw_valid_next", 64'(draw_valid), 64'd1);
            chk("draw_head", 64'(draw_data), 64'(tbl[v].exp));
            chk("draw_busy_end", 64'(busy), 64'd0);
            pop1;
            chk("draw_valid_after_pop", 64'(draw_valid), 64'd0);
        end

        // abort after 100 pixels; abort beats the same-cycle byte
        w0 = n_writes; d0 = n_done;
        send(1'b1, 8'h00, SAVE, 16'd0);
        send(1'b0, SAVE, 8'h05, 16'd0);
        for (int k = 1; k <= 100; k++) begin
            wq.push_back('{addr: 13'h0A00 + 13'(k - 1), wd: 8'(k + 3), done: 1'b0});
            send(1'b0, SAVE, 8'(k + 3), 16'(k));
        end
        abort = 1'b1;
        send(1'b0, SAVE, 8'hEE, 16'd101);
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        idle(3);
        chk("abort_write_count", 64'(n_writes - w0), 64'd100);
        chk("abort_no_done", 64'(n_done - d0), 64'd0);
        send_draw(2, 1'b0);
        dq.push_back(tbl[2].exp);
        chk("post_abort_draw_valid", 64'(draw_valid), 64'd1);
        chk("post_abort_draw_data", 64'(draw_data), 64'(tbl[2].exp));
        pop1;

        // overflow: five draws into depth 4, fifth dropped
        for (int v = 0; v < 5; v++) begin
            send_draw(v, 1'b0);
            if (v < 4) dq.push_back(tbl[v].exp);
        end
        chk("ovf_set", 64'(draw_overflow), 64'd1);
        pop1;
        pop1;
        chk("ovf_order_head", 64'(draw_data), 64'(tbl[2].exp));

        // reset with two entries queued and overflow set
        reset = 1'b0;
        idle(1);
        chk("rst2_sprite_we", 64'(sprite_we), 64'd0);
        chk("rst2_sprite_addr", 64'(sprite_addr), 64'd0);
        chk("rst2_sprite_wdata", 64'(sprite_wdata), 64'd0);
        chk("rst2_save_done", 64'(save_done), 64'd0);
        chk("rst2_draw_valid", 64'(draw_valid), 64'd0);
        chk("rst2_draw_data", 64'(draw_data), 64'd0);
        chk("rst2_overflow", 64'(draw_overflow), 64'd0);
        chk("rst2_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        dq.delete();
        idle(1);

        // full FIFO with same-cycle pop accepts the new entry
        for (int v = 0; v < 4; v++) begin
            send_draw(v, 1'b0);
            dq.push_back(tbl[v].exp);
        end
        dq.push_back(tbl[5].exp);
        send_draw(5, 1'b1);
        chk("pushpop_no_ovf", 64'(draw_overflow), 64'd0);
        for (int i = 0; i < 4; i++) pop1;
        chk("pushpop_drained", 64'(draw_valid), 64'd0);
        chk("pushpop_all_seen", 64'(dq.size()), 64'd0);

        // opcode mid-draw abandons the draw; the SAVE completes normally
        w0 = n_writes; d0 = n_done;
        send(1'b1, 8'h00, DRAW, 16'd0);
        send(1'b0, DRAW, tbl[3].id, 16'd0);
        send(1'b0, DRAW, tbl[3].x[15:8], 16'd1);
        send(1'b0, DRAW, tbl[3].x[7:0], 16'd2);
        save_all(4'hA, 7, 0);
        idle(2);
        chk("mid_no_push", 64'(draw_valid), 64'd0);
        chk("mid_write_count", 64'(n_writes - w0), 64'd512);
        chk("mid_done_count", 64'(n_done - d0), 64'd1);

        // out-of-order pixel index drops the command
        w0 = n_writes;
        send(1'b1, 8'h00, SAVE, 16'd0);
        send(1'b0, SAVE, 8'h01, 16'd0);
        wq.push_back('{addr: 13'h0200, wd: 8'h55, done: 1'b0});
        send(1'b0, SAVE, 8'h55, 16'd1);
        send(1'b0, SAVE, 8'h66, 16'd3);
        chk("badidx_busy", 64'(busy), 64'd0);
        send(1'b0, SAVE, 8'h77, 16'd2);
        idle(2);
        chk("badidx_write_count", 64'(n_writes - w0), 64'd1);

        chk("final_wq_empty", 64'(wq.size()), 64'd0);
        chk("final_dq_empty", 64'(dq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_command_executor.md
# spi_command_executor

Consumes the byte stream decoded by the SPI command parser and executes sprite commands. COMMAND_SAVE_SPRITE payloads become sprite-memory write strobes. COMMAND_DRAW_SPRITE payloads are assembled into 48-bit draw requests and queued in a small FIFO for the renderer. It sits between the SPI receive path and the sprite RAM / draw pipeline.

## Interface
- SPRITE_ID_WIDTH, 4: sprite-id bits used (id byte truncated to this width).
- DRAW_FIFO_DEPTH, 4: draw-request FIFO entries (power of two, ≥2).
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- abort  in  1  SPI chip-select deasserted (high = transfer ended); discards partial command.
- byte_read  in  1  one-cycle strobe: data/command/data_index/cmd_byte valid this cycle.
- cmd_byte  in  1  with byte_read: data is an opcode byte, not payload.
- command  in  8  opcode the payload byte belongs to.
- data  in  8  received byte.
- data_index  in  16  0-based payload position of data.
- sprite_we  out  1  sprite RAM write enable, one cycle per pixel.
- sprite_addr  out  SPRITE_ID_WIDTH+9  {sprite_id, pixel_index[8:0]}.
- sprite_wdata  out  8  pixel value.
- save_done  out  1  one-cycle pulse after pixel 511 written.
- draw_valid  out  1  FIFO non-empty.
- draw_ready  in  1  consumer accepts head entry.
- draw_data  out  48  {id[7:0], x[15:0], y[15:0], flags[7:0]} of FIFO head.
- draw_overflow  out  1  sticky: a completed draw request was dropped.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, SAVE_ID, SAVE_PIX, DRAW_COLLECT.
- IDLE: byte_read & cmd_byte & data==COMMAND_SAVE_SPRITE → SAVE_ID; data==COMMAND_DRAW_SPRITE → DRAW_COLLECT, clear collect counter; any other opcode stays IDLE; payload bytes in IDLE ignored.
- SAVE_ID: payload byte with data_index 0 latches sprite_id = data[SPRITE_ID_WIDTH-1:0] → SAVE_PIX.
- SAVE_PIX: payload byte with data_index k (1..512) issues write: addr {sprite_id, (k-1)[8:0]}, wdata = data. After k=512: save_done pulse with that write's cycle, → IDLE.
- DRAW_COLLECT: bytes index 0..5 fill id, x[15:8], x[7:0], y[15:8], y[7:0], flags. At index 5: push assembled entry, → IDLE.
- Payload byte whose command mismatches the current state's command, or whose data_index differs from the expected next index: discard command, → IDLE, no write/push for that byte.
- A cmd_byte while not IDLE: abandon current command, process the opcode as from IDLE.
- abort (any state): → IDLE next cycle. SAVE writes already issued stand; partial draw discarded. abort outranks same-cycle byte_read.
- FIFO: push on completed draw if not full, or if full with same-cycle pop (draw_valid & draw_ready). Full without pop: drop entry, set draw_overflow. draw_overflow clears only on reset.
- draw_data = head entry; undefined content is not permitted: 0 when empty.

## Timing
- Reset (reset=0 at edge): state IDLE, sprite_we 0, sprite_addr 0, sprite_wdata 0, save_done 0, FIFO empty, draw_valid 0, draw_data 0, draw_overflow 0, busy 0. Reset outranks abort and byte_read.
- Write latency: sprite_we/addr/wdata registered, high exactly the cycle after the byte_read cycle; addr/wdata hold last value when sprite_we=0.
- save_done: asserted the same cycle as the 512th sprite_we.
- Draw latency: 6th byte at cycle N → draw_valid=1 at N+1 (FIFO previously empty).
- Pop: entry removed at edge where draw_valid & draw_ready; next entry visible the following cycle.
- busy: registered state; 1 the cycle after the opcode byte, 0 the cycle after completion/abort.
- Back-to-back byte_read on consecutive cycles must be handled with no loss.

## Test plan
- SAVE: opcode, id 0x03, pixels 0x00..0xFF,0x00..0xFF → 512 writes addr 0x0600..0x07FF, wdata = byte, save_done with last write, busy then 0.
- DRAW: opcode, 0x07,0x01,0x2C,0x00,0xC8,0x81, draw_ready=0 → draw_valid next cycle, draw_data 0x07_012C_00C8_81; raise ready → popped, draw_valid 0.
- Overflow: 5 draws, draw_ready=0, depth 4 → 4 queued in order, draw_overflow=1; simultaneous pop+push on full FIFO → no overflow set.
- Abort: SAVE after 100 pixels, abort=1 → exactly 100 writes, no save_done, IDLE; following DRAW executes normally.
- Mid-command opcode: DRAW after 3 bytes, new SAVE opcode → no push, SAVE proceeds correctly.
- Reset: reset=0 with 2 FIFO entries and overflow set → all outputs at reset values next cycle.
